// File: rtl/keypad_scan_fifo.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_fifo
// Purpose  : 4x4 matrix keypad scanner with press/release debounce and a
//            small code FIFO read through a status/data CPU window.
// Revision : 1.0  initial release
// ============================================================================
module keypad_scan_fifo #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  rowwrite,
  input  logic [3:0]  colread,
  input  logic        ack,
  input  logic        statusordata,
  output logic [15:0] keyout
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DB_W  = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [DIV_W-1:0] c_div_last  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  c_db_last   = DB_W'(DEBOUNCE_SCANS - 1);
  localparam logic [CNT_W-1:0] c_fifo_full = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] c_st_scan     = 2'd0;
  localparam logic [1:0] c_st_debounce = 2'd1;
  localparam logic [1:0] c_st_wait_rel = 2'd2;

  logic [DIV_W-1:0] r_div;
  logic             w_tick;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [1:0]       r_row;
  logic [1:0]       r_col;
  logic [DB_W-1:0]  r_cnt;
  logic [3:0]       r_rowwrite;

  logic             w_any_low;
  logic             w_col_low;
  logic [1:0]       w_col_hit;
  logic [1:0]       w_row_next;
  logic [3:0]       w_code;

  logic             w_latch;
  logic             w_row_inc;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic             w_push;

  logic [3:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_ack_q;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_wr;

  // --------------------------------------------------------------------------
  // Scan tick divider
  // --------------------------------------------------------------------------
  assign w_tick = (r_div == c_div_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Column decode: lowest-index low column wins on multi-key rows
  // --------------------------------------------------------------------------
  assign w_any_low  = (colread != 4'hF);
  assign w_col_low  = ~colread[r_col];
  assign w_row_next = r_row + 2'd1;
  assign w_code     = {r_row, r_col};

  always_comb begin
    w_col_hit = 2'd3;
    if (!colread[0]) begin
      w_col_hit = 2'd0;
    end else if (!colread[1]) begin
      w_col_hit = 2'd1;
    end else if (!colread[2]) begin
      w_col_hit = 2'd2;
    end
  end

  // --------------------------------------------------------------------------
  // Scan FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_scan;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_tick) begin
      case (r_state)
        c_st_scan: begin
          if (w_any_low) begin
            w_state_nxt = c_st_debounce;
          end
        end
        c_st_debounce: begin
          if (!w_col_low) begin
            w_state_nxt = c_st_scan;
          end else if (r_cnt == c_db_last) begin
            w_state_nxt = c_st_wait_rel;
          end
        end
        c_st_wait_rel: begin
          if (!w_any_low && (r_cnt == c_db_last)) begin
            w_state_nxt = c_st_scan;
          end
        end
        default: w_state_nxt = c_st_scan;
      endcase
    end
  end

  always_comb begin
    w_latch   = 1'b0;
    w_row_inc = 1'b0;
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    w_push    = 1'b0;
    if (w_tick) begin
      case (r_state)
        c_st_scan: begin
          if (w_any_low) begin
            w_latch   = 1'b1;
            w_cnt_clr = 1'b1;
          end else begin
            w_row_inc = 1'b1;
          end
        end
        c_st_debounce: begin
          if (!w_col_low) begin
            w_row_inc = 1'b1;
          end else if (r_cnt == c_db_last) begin
            w_push    = 1'b1;
            w_cnt_clr = 1'b1;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
        c_st_wait_rel: begin
          // Any low column restarts the release qualification window.
          if (w_any_low) begin
            w_cnt_clr = 1'b1;
          end else if (r_cnt == c_db_last) begin
            w_row_inc = 1'b1;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row      <= 2'd0;
      r_col      <= 2'd0;
      r_cnt      <= '0;
      r_rowwrite <= 4'b1110;
    end else begin
      if (w_row_inc) begin
        r_row      <= w_row_next;
        r_rowwrite <= ~(4'b0001 << w_row_next);
      end
      if (w_latch) begin
        r_col <= w_col_hit;
      end
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + DB_W'(1);
      end
    end
  end

  assign rowwrite = r_rowwrite;

  // --------------------------------------------------------------------------
  // Code FIFO
  // --------------------------------------------------------------------------
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_fifo_full);
  assign w_pop   = ack & ~r_ack_q & ~w_empty;
  // A full FIFO still accepts a push when the same edge frees a slot.
  assign w_wr    = w_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_ack_q    <= 1'b0;
    end else begin
      r_ack_q <= ack;
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end else if (w_pop && !(w_push && w_full)) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_comb begin
    keyout = 16'h0000;
    if (statusordata) begin
      keyout = {14'b0, r_overflow, ~w_empty};
    end else if (!w_empty) begin
      keyout = {12'b0, r_mem[r_rd_ptr]};
    end
  end

endmodule
`default_nettype wire
